// File: rtl/vip_matrix_3x3_gen_if.sv
// Streaming pixel interface for the 3x3 neighbourhood generator.
// Carries the incoming gray stream (per_img_*) and the outgoing window
// stream (matrix_*).
//   slave  : generator side (consumes per_img_*, produces matrix_*)
//   master : upstream/downstream environment side
interface vip_matrix_3x3_gen_if;
    logic        per_img_vsync;
    logic        per_img_href;
    logic [7:0]  per_img_gray;
    logic        matrix_img_vsync;
    logic        matrix_img_href;
    logic [71:0] matrix_data;
    logic        matrix_full_flag;

    modport slave (
        input  per_img_vsync,
        input  per_img_href,
        input  per_img_gray,
        output matrix_img_vsync,
        output matrix_img_href,
        output matrix_data,
        output matrix_full_flag
    );

    modport master (
        output per_img_vsync,
        output per_img_href,
        output per_img_gray,
        input  matrix_img_vsync,
        input  matrix_img_href,
        input  matrix_data,
        input  matrix_full_flag
    );
endinterface

// File: rtl/vip_matrix_3x3_gen.sv
// Streaming 3x3 neighbourhood generator for 8-bit gray video.
// Every valid input pixel (row r, col c) yields one 3x3 window two cycles
// later: row 3 = row r, row 2 = r-1, row 1 = r-2; column 3 = c, 2 = c-1,
// 1 = c-2. Two line buffers keep the previous two rows.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   ifc    : vip_matrix_3x3_gen_if.slave
//            per_img_vsync/href/gray in; matrix_img_vsync/href,
//            matrix_data[71:0] (p11 at [71:64] .. p33 at [7:0]),
//            matrix_full_flag out
// Build option:
//   VIP_MATRIX_EDGE_REPLICATE_EN defined  -> out-of-image taps replicate the
//   nearest in-image pixel; undefined -> out-of-image taps are 0x00.
module vip_matrix_3x3_gen #(
    parameter int unsigned IMG_WIDTH  = 500,
    parameter int unsigned IMG_HEIGHT = 500
) (
    input  logic                  clk,
    input  logic                  rst_n,
    vip_matrix_3x3_gen_if.slave   ifc
);
    localparam int unsigned CW = $clog2(IMG_WIDTH + 1);
    localparam int unsigned RW = $clog2(IMG_HEIGHT + 1);
    localparam int unsigned AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

    logic [CW-1:0]   col_cnt;
    logic [RW-1:0]   row_cnt;
    logic            frame_active;
    logic            vsync_d;
    logic            href_d;

    logic            vs_rise_c;
    logic            vs_fall_c;
    logic            pix_valid_c;
    logic [CW-1:0]   col_eff_c;
    logic [RW-1:0]   row_eff_c;
    logic            over_c;
    logic [AW-1:0]   lb_addr_c;

    logic [7:0]      line1 [IMG_WIDTH];
    logic [7:0]      line2 [IMG_WIDTH];

    logic            s1_valid;
    logic            s1_vsync;
    logic [7:0]      s1_gray;
    logic [7:0]      s1_l1;
    logic [7:0]      s1_l2;
    logic            s1_r1;
    logic            s1_r2;
    logic            s1_c0;
    logic            s1_c1;
    logic            s1_over;
    logic            s1_full;

    logic [0:2][7:0]       col_new_c;
    logic [0:2][0:2][7:0]  win_nxt_c;
    logic [0:2][0:2][7:0]  win_q;
    logic                  full_q;
    logic                  vsync_q;
    logic                  href_q;

    // Frame-start pixel is forced to (0,0) even before the counters clear.
    assign vs_rise_c   = ifc.per_img_vsync & ~vsync_d;
    assign vs_fall_c   = ~ifc.per_img_vsync & vsync_d;
    assign pix_valid_c = ifc.per_img_href & ifc.per_img_vsync & (frame_active | vs_rise_c);
    assign col_eff_c   = vs_rise_c ? '0 : col_cnt;
    assign row_eff_c   = vs_rise_c ? '0 : row_cnt;
    assign over_c      = (col_eff_c >= CW'(IMG_WIDTH));
    assign lb_addr_c   = AW'(col_eff_c);

    // Position counters and frame tracking. vsync_d resets high so a reset
    // released mid-frame is not mistaken for a frame start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_cnt      <= '0;
            row_cnt      <= '0;
            frame_active <= 1'b0;
            vsync_d      <= 1'b1;
            href_d       <= 1'b0;
        end else begin
            vsync_d <= ifc.per_img_vsync;
            href_d  <= ifc.per_img_href;
            if (vs_rise_c) begin
                frame_active <= 1'b1;
                row_cnt      <= '0;
                col_cnt      <= ifc.per_img_href ? CW'(1) : '0;
            end else if (vs_fall_c) begin
                frame_active <= 1'b0;
            end else if (frame_active) begin
                if (!ifc.per_img_href)
                    col_cnt <= '0;
                else if (col_cnt != CW'(IMG_WIDTH))
                    col_cnt <= col_cnt + CW'(1);
                if (href_d && !ifc.per_img_href && (row_cnt != RW'(IMG_HEIGHT)))
                    row_cnt <= row_cnt + RW'(1);
            end
        end
    end

    // Line buffers: read-before-write, overlong pixels are not stored.
    always_ff @(posedge clk) begin
        if (rst_n && pix_valid_c && !over_c) begin
            line1[lb_addr_c] <= ifc.per_img_gray;
            line2[lb_addr_c] <= line1[lb_addr_c];
        end
    end

    // Stage 1: capture pixel, buffer taps and position flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_vsync <= 1'b0;
            s1_gray  <= '0;
            s1_l1    <= '0;
            s1_l2    <= '0;
            s1_r1    <= 1'b0;
            s1_r2    <= 1'b0;
            s1_c0    <= 1'b0;
            s1_c1    <= 1'b0;
            s1_over  <= 1'b0;
            s1_full  <= 1'b0;
        end else begin
            s1_valid <= pix_valid_c;
            s1_vsync <= ifc.per_img_vsync & (frame_active | vs_rise_c);
            if (pix_valid_c) begin
                s1_gray <= ifc.per_img_gray;
                s1_l1   <= line1[lb_addr_c];
                s1_l2   <= line2[lb_addr_c];
                s1_r1   <= (row_eff_c != '0);
                s1_r2   <= (row_eff_c >= RW'(2));
                s1_c0   <= (col_eff_c == '0);
                s1_c1   <= (col_eff_c == CW'(1));
                s1_over <= over_c;
                s1_full <= (row_eff_c >= RW'(2)) && (col_eff_c >= CW'(2)) && !over_c;
            end
        end
    end

    // Next window: mask/replicate the new column, then shift it in.
    always_comb begin
        col_new_c = '0;
        win_nxt_c = '0;
        col_new_c[0] = s1_l2;
        col_new_c[1] = s1_l1;
        col_new_c[2] = s1_gray;
`ifdef VIP_MATRIX_EDGE_REPLICATE_EN
        if (!s1_r1) begin
            col_new_c[0] = s1_gray;
            col_new_c[1] = s1_gray;
        end else if (!s1_r2) begin
            col_new_c[0] = s1_l1;
        end
`else
        if (!s1_r1) col_new_c[1] = 8'h00;
        if (!s1_r2) col_new_c[0] = 8'h00;
`endif
        for (int i = 0; i < 3; i++) begin
            win_nxt_c[i] = {win_q[i][1], win_q[i][2], col_new_c[i]};
`ifdef VIP_MATRIX_EDGE_REPLICATE_EN
            if (s1_c0)      win_nxt_c[i] = {3{col_new_c[i]}};
            else if (s1_c1) win_nxt_c[i][0] = win_q[i][2];
`else
            if (s1_c0)      win_nxt_c[i] = {16'h0000, col_new_c[i]};
            else if (s1_c1) win_nxt_c[i][0] = 8'h00;
`endif
        end
        // Beyond the line-buffer width only the current row is meaningful.
        if (s1_over) begin
            win_nxt_c[0] = '0;
            win_nxt_c[1] = '0;
        end
    end

    // Stage 2: window register; holds its value between valid pixels.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_q   <= '0;
            full_q  <= 1'b0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
        end else begin
            vsync_q <= s1_vsync;
            href_q  <= s1_valid;
            if (s1_valid) begin
                win_q  <= win_nxt_c;
                full_q <= s1_full;
            end
        end
    end

    assign ifc.matrix_img_vsync = vsync_q;
    assign ifc.matrix_img_href  = href_q;
    assign ifc.matrix_data      = win_q;
    assign ifc.matrix_full_flag = full_q;
endmodule

// File: tb/tb_vip_matrix_3x3_gen.sv
// Testbench for vip_matrix_3x3_gen: 4-wide, 4-row frames, pixel(r,c) =
// 16r + c + 1 (optionally XOR-ed). Expected windows are pushed when pixels
// are driven and compared against windows captured from the output stream.
`timescale 1ns/1ps
module tb_vip_matrix_3x3_gen;
    localparam int W = 4;
    localparam int H = 4;

`ifdef VIP_MATRIX_EDGE_REPLICATE_EN
    localparam logic [71:0] K00  = 72'h010101_010101_010101;
    localparam logic [71:0] K11  = 72'h010102_010102_111112;
    localparam logic [71:0] K01X = 72'h818182_818182_818182;
`else
    localparam logic [71:0] K00  = 72'h000000_000000_000001;
    localparam logic [71:0] K11  = 72'h000000_000102_001112;
    localparam logic [71:0] K01X = 72'h000000_000000_008182;
`endif
    localparam logic [71:0] K22  = 72'h010203_111213_212223;
    localparam logic [71:0] K24L = 72'h000000_000000_232425;

    typedef struct {
        logic [71:0] data;
        logic        full;
        int          cyc;
        int          r;
        int          c;
    } exp_t;

    typedef struct {
        logic [71:0] data;
        logic        full;
        int          cyc;
    } obs_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_fail;
    exp_t exp_q[$];
    obs_t obs_q[$];
    obs_t mon_o;

    vip_matrix_3x3_gen_if ifc();

    vip_matrix_3x3_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ifc   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: capture every produced window.
    always @(negedge clk) begin
        if (ifc.matrix_img_href === 1'b1) begin
            mon_o.data = ifc.matrix_data;
            mon_o.full = ifc.matrix_full_flag;
            mon_o.cyc  = cyc;
            obs_q.push_back(mon_o);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    function automatic logic [7:0] pix(input int r, input int c, input logic [7:0] xm);
        return 8'(16 * r + c + 1) ^ xm;
    endfunction

    // Reference window built by geometry, independent of the shift pipeline.
    function automatic logic [71:0] exp_win(input int r, input int c, input logic [7:0] xm);
        logic [71:0] w;
        logic [7:0]  v;
        int rr;
        int cc;
        w = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                rr = r - 2 + i;
                cc = c - 2 + j;
`ifdef VIP_MATRIX_EDGE_REPLICATE_EN
                if (rr < 0) rr = 0;
                if (cc < 0) cc = 0;
`endif
                if (rr < 0 || cc < 0)      v = 8'h00;
                else if (i < 2 && c >= W)  v = 8'h00;
                else                       v = pix(rr, cc, xm);
                w[71 - 8 * (3 * i + j) -: 8] = v;
            end
        end
        return w;
    endfunction

    // Drives one 4-row frame; optionally pulses reset at (rst_r,rst_c),
    // lengthens row long_row by one pixel, and raises vsync with (0,0).
    task automatic drive_frame(input logic [7:0] xm, input int rst_r, input int rst_c,
                               input int long_row, input int gap, input bit vs_with_pix);
        exp_t e;
        bit   act;
        bit   pushed_prev;
        int   ncols;
        act = 1'b1;
        pushed_prev = 1'b0;
        @(negedge clk);
        ifc.per_img_vsync = 1'b1;
        ifc.per_img_href  = 1'b0;
        if (!vs_with_pix) repeat (2) @(negedge clk);
        for (int r = 0; r < H; r++) begin
            ncols = (r == long_row) ? W + 1 : W;
            for (int c = 0; c < ncols; c++) begin
                if (r == rst_r && c == rst_c) begin
                    rst_n = 1'b0;
                    // The previous pixel is still in flight and gets flushed.
                    if (act && pushed_prev) exp_q.delete(exp_q.size() - 1);
                    act = 1'b0;
                end else begin
                    rst_n = 1'b1;
                end
                ifc.per_img_href = 1'b1;
                ifc.per_img_gray = pix(r, c, xm);
                pushed_prev = 1'b0;
                if (act) begin
                    e.data = exp_win(r, c, xm);
                    e.full = (r >= 2 && c >= 2 && c < W);
                    e.cyc  = cyc + 2;
                    e.r    = r;
                    e.c    = c;
                    exp_q.push_back(e);
                    pushed_prev = 1'b1;
                end
                @(negedge clk);
            end
            ifc.per_img_href = 1'b0;
            rst_n = 1'b1;
            pushed_prev = 1'b0;
            repeat (gap) @(negedge clk);
        end
        ifc.per_img_vsync = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ifc.per_img_vsync = 1'b1;
        for (int k = 0; k < 22; k++) begin
            @(negedge clk);
            n_cmp++;
            if (ifc.matrix_img_vsync !== 1'b0 || ifc.matrix_img_href !== 1'b0 ||
                ifc.matrix_data !== 72'h0 || ifc.matrix_full_flag !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_outputs k=%0d: got vs=%b hr=%b data=%h full=%b expected all zero",
                         k, ifc.matrix_img_vsync, ifc.matrix_img_href, ifc.matrix_data,
                         ifc.matrix_full_flag);
            end
            if (k == 9) rst_n = 1'b1;
            ifc.per_img_href = ((k % 5) < 4);
            ifc.per_img_gray = 8'(k + 1);
        end
        ifc.per_img_vsync = 1'b0;
        ifc.per_img_href  = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_no_href: got %0d windows expected 0", obs_q.size());
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_basic_frame();
        exp_t e;
        obs_t o;
        int   nfull;
        drive_frame(8'h00, -1, -1, -1, 5, 1'b0);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL basic_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        if (obs_q.size() >= 11) begin
            n_cmp += 3;
            if (obs_q[0].data !== K00 || obs_q[0].full !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_p00: got %h/%b expected %h/0", obs_q[0].data, obs_q[0].full, K00);
            end
            if (obs_q[5].data !== K11 || obs_q[5].full !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_p11: got %h/%b expected %h/0", obs_q[5].data, obs_q[5].full, K11);
            end
            if (obs_q[10].data !== K22 || obs_q[10].full !== 1'b1) begin
                n_fail++;
                $display("FAIL basic_p22: got %h/%b expected %h/1", obs_q[10].data, obs_q[10].full, K22);
            end
        end
        nfull = 0;
        foreach (obs_q[i]) if (obs_q[i].full === 1'b1) nfull++;
        n_cmp++;
        if (nfull != 4) begin
            n_fail++;
            $display("FAIL basic_full_count: got %0d expected 4", nfull);
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o.data !== e.data || o.full !== e.full || o.cyc != e.cyc) begin
                n_fail++;
                $display("FAIL basic_win(%0d,%0d): got %h/%b@%0d expected %h/%b@%0d",
                         e.r, e.c, o.data, o.full, o.cyc, e.data, e.full, e.cyc);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_stale_mask();
        exp_t e;
        obs_t o;
        drive_frame(8'h80, -1, -1, -1, 5, 1'b1);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL stale_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        if (obs_q.size() >= 2) begin
            n_cmp++;
            if (obs_q[1].data !== K01X || obs_q[1].full !== 1'b0) begin
                n_fail++;
                $display("FAIL stale_p01: got %h/%b expected %h/0", obs_q[1].data, obs_q[1].full, K01X);
            end
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o.data !== e.data || o.full !== e.full || o.cyc != e.cyc) begin
                n_fail++;
                $display("FAIL stale_win(%0d,%0d): got %h/%b@%0d expected %h/%b@%0d",
                         e.r, e.c, o.data, o.full, o.cyc, e.data, e.full, e.cyc);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_mid_reset();
        exp_t e;
        obs_t o;
        drive_frame(8'h00, 2, 1, -1, 5, 1'b0);
        n_cmp++;
        if (ifc.matrix_img_vsync !== 1'b0 || ifc.matrix_img_href !== 1'b0 ||
            ifc.matrix_data !== 72'h0 || ifc.matrix_full_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got vs=%b hr=%b data=%h full=%b expected all zero",
                     ifc.matrix_img_vsync, ifc.matrix_img_href, ifc.matrix_data, ifc.matrix_full_flag);
        end
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL midrst_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o.data !== e.data || o.full !== e.full || o.cyc != e.cyc) begin
                n_fail++;
                $display("FAIL midrst_win(%0d,%0d): got %h/%b@%0d expected %h/%b@%0d",
                         e.r, e.c, o.data, o.full, o.cyc, e.data, e.full, e.cyc);
            end
        end
        exp_q.delete();
        obs_q.delete();

        drive_frame(8'h00, -1, -1, -1, 5, 1'b0);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL postrst_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        if (obs_q.size() >= 1) begin
            n_cmp++;
            if (obs_q[0].data !== K00 || obs_q[0].full !== 1'b0) begin
                n_fail++;
                $display("FAIL postrst_p00: got %h/%b expected %h/0", obs_q[0].data, obs_q[0].full, K00);
            end
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o.data !== e.data || o.full !== e.full || o.cyc != e.cyc) begin
                n_fail++;
                $display("FAIL postrst_win(%0d,%0d): got %h/%b@%0d expected %h/%b@%0d",
                         e.r, e.c, o.data, o.full, o.cyc, e.data, e.full, e.cyc);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_back_to_back_overlong();
        exp_t e;
        obs_t o;
        int   nfull;
        drive_frame(8'h00, -1, -1, 2, 1, 1'b0);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        if (obs_q.size() >= 13) begin
            n_cmp++;
            if (obs_q[12].data !== K24L || obs_q[12].full !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_overlong: got %h/%b expected %h/0", obs_q[12].data, obs_q[12].full, K24L);
            end
        end
        nfull = 0;
        foreach (obs_q[i]) if (obs_q[i].full === 1'b1) nfull++;
        n_cmp++;
        if (nfull != 4) begin
            n_fail++;
            $display("FAIL b2b_full_count: got %0d expected 4", nfull);
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o.data !== e.data || o.full !== e.full || o.cyc != e.cyc) begin
                n_fail++;
                $display("FAIL b2b_win(%0d,%0d): got %h/%b@%0d expected %h/%b@%0d",
                         e.r, e.c, o.data, o.full, o.cyc, e.data, e.full, e.cyc);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        ifc.per_img_vsync = 1'b0;
        ifc.per_img_href  = 1'b0;
        ifc.per_img_gray  = 8'h00;
        test_reset();
        test_basic_frame();
        test_stale_mask();
        test_mid_reset();
        test_back_to_back_overlong();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/vip_matrix_3x3_gen.md
# vip_matrix_3x3_gen

Streaming 3x3 neighbourhood generator for 8-bit gray video. It sits directly downstream of the histogram-equalisation stage and consumes its post_img_vsync/href/gray stream. For every input pixel it emits one 3x3 window, so later spatial filters (mean, Sobel, median) have a complete neighbourhood on every valid cycle. Two internal line buffers hold the previous two rows.

## Interface
- IMG_WIDTH, 500: maximum pixels per row; sets line-buffer depth.
- IMG_HEIGHT, 500: rows per frame; the row counter saturates at this value.
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- per_img_vsync  in  1  frame active, high for the whole frame.
- per_img_href  in  1  pixel valid, high for each pixel of a row.
- per_img_gray  in  8  pixel value.
- matrix_img_vsync  out  1  per_img_vsync delayed 2 cycles.
- matrix_img_href  out  1  per_img_href delayed 2 cycles.
- matrix_data  out  72  window p11..p33 packed: p11=[71:64], p12=[63:56], p13=[55:48], p21=[47:40], ..., p33=[7:0].
- matrix_full_flag  out  1  window lies entirely inside the image.

## Operation
- Geometry: an input pixel at row r, column c produces one window.
  - Row 3 (p3x) is row r, row 2 is row r-1, row 1 is row r-2.
  - Column 3 (px3) is column c, column 2 is c-1, column 1 is c-2.
- Counters:
  - col_cnt increments on each href-high cycle and clears when href is low.
  - row_cnt increments on each href falling edge and saturates at IMG_HEIGHT.
  - On a vsync rising edge, both counters clear and frame_active is set.
  - frame_active clears on a vsync falling edge.
- Line buffers: line1 holds row r-1 and line2 holds row r-2, each IMG_WIDTH x 8 bits, addressed by col_cnt.
  - Each valid pixel reads line1[c] and line2[c], then writes line1[c] = pixel and line2[c] = old line1[c] (read-before-write).
- Column pipeline: three 8-bit shift registers per row, advanced only on valid pixels. When col_cnt = 0 they load the row's first column fresh.
- Out-of-image positions (row < 0 or column < 0) are forced to 0x00. This masking is driven by the counters, never by stale buffer contents.
- matrix_full_flag = (r >= 2) && (c >= 2), registered alongside the data.
- Overlong rows (col_cnt >= IMG_WIDTH): the pixel is not written to the line buffers, p1x/p2x output as 0x00, full_flag = 0, and col_cnt saturates.
- Inputs arriving while frame_active = 0 (including after reset released mid-frame) are ignored. Outputs stay 0 until the next vsync rising edge.

## Timing
- Reset values: matrix_img_vsync = 0, matrix_img_href = 0, matrix_data = 0, matrix_full_flag = 0, counters = 0, frame_active = 0. Line-buffer contents are don't-care.
- Latency is 2 cycles (buffer read, then window register). matrix_data and full_flag are valid exactly when matrix_img_href = 1. When href = 0, matrix_data holds its last value.
- Back-to-back pixels are accepted every cycle; there is no backpressure.
- Horizontal gaps of any length between rows are supported.
- Simultaneous vsync rise and href high: the counters clear first, and that pixel is treated as (0,0).
- Reset asserted mid-frame: all outputs return to their reset values on the next clock edge.

## Configuration
- VIP_MATRIX_EDGE_REPLICATE_EN:
  - Defined: out-of-image positions replicate the nearest in-image pixel.
    - r = 0: rows 1 and 2 copy row 3. r = 1: row 1 copies row 2.
    - c = 0: columns 1 and 2 copy column 3. c = 1: column 1 copies column 2.
  - Undefined: out-of-image positions are 0x00.
  - matrix_full_flag is identical in both builds.

## Test plan
Common stimulus: IMG_WIDTH = 4, 4x4 frame with pixel(r,c) = 16r + c + 1, 5 idle cycles between rows.
- Reset: hold rst_n = 0 for 10 cycles while driving stimulus -> all outputs 0, no href pulses.
- Input (0,0) = 0x01 -> two cycles later matrix_img_href = 1, p33 = 0x01, the other eight entries 0x00, full_flag = 0.
- Input (2,2) = 0x23 -> two cycles later p11..p13 = 01,02,03; p21..p23 = 11,12,13; p31..p33 = 21,22,23; full_flag = 1. Exactly 4 full windows per frame.
- Second frame with pixel values XOR 0x80, (0,1) = 0x82 -> p32 = 0x81, p33 = 0x82, rows 1-2 = 0x00. Proves frame-start masking of stale buffer data.
- Pulse rst_n low for 1 cycle at (2,1), then continue stimulus -> outputs 0 and no href for the rest of that frame. The next frame's (0,0) output matches the (0,0) case above.
- Build with VIP_MATRIX_EDGE_REPLICATE_EN, input (0,0) = 0x01 -> all nine entries 0x01, full_flag = 0. (1,1) = 0x12 -> p11 = p12 = p21 = p22 = 0x01, p13 = p23 = 0x02, p31 = p32 = 0x11, p33 = 0x12.
